// File: rtl/ex_muldiv_unit_if.sv
// Issue/result bus between the ID/EX stage and the iterative muldiv unit.
// Compile-time option MULDIV_DIVZERO_EN adds the DivZero pulse to the bus.
interface ex_muldiv_unit_if #(parameter int WIDTH = 32);
   logic             Start;
   logic             Flush;
   logic [5:0]       E_func;
   logic [WIDTH-1:0] E_busA;
   logic [WIDTH-1:0] E_busB;
   logic             Busy;
   logic [WIDTH-1:0] Result;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;
`ifdef MULDIV_DIVZERO_EN
   logic             DivZero;
   modport master (output Start, Flush, E_func, E_busA, E_busB,
                   input  Busy, Result, HI, LO, DivZero);
   modport slave  (input  Start, Flush, E_func, E_busA, E_busB,
                   output Busy, Result, HI, LO, DivZero);
`else
   modport master (output Start, Flush, E_func, E_busA, E_busB,
                   input  Busy, Result, HI, LO);
   modport slave  (input  Start, Flush, E_func, E_busA, E_busB,
                   output Busy, Result, HI, LO);
`endif
endinterface

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative radix-2 multiply/divide unit owning HI/LO.
// Define MULDIV_DIVZERO_EN to trap divide-by-zero at issue (DivZero pulse, no RUN).
module ex_muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic             Clk,
   input logic             Rst,
   ex_muldiv_unit_if.slave mdu
);
   localparam logic [5:0] F_MFHI = 6'h10;
   localparam logic [5:0] F_MTHI = 6'h11;
   localparam logic [5:0] F_MFLO = 6'h12;
   localparam logic [5:0] F_MTLO = 6'h13;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic [WIDTH-1:0]   acc_hi, acc_lo, opnd_b;
   logic               op_mul, sign_p, sign_r;

   logic               is_md, is_div, is_signed, dz, issue;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0] prod_neg;

   always_comb begin
      is_md     = (mdu.E_func[5:2] == 4'b0110);
      is_div    = is_md & mdu.E_func[1];
      is_signed = ~mdu.E_func[0];
      abs_a     = (is_signed & mdu.E_busA[WIDTH-1]) ? -mdu.E_busA : mdu.E_busA;
      abs_b     = (is_signed & mdu.E_busB[WIDTH-1]) ? -mdu.E_busB : mdu.E_busB;
   end

`ifdef MULDIV_DIVZERO_EN
   assign dz          = is_div & (mdu.E_busB == '0);
   assign mdu.DivZero = (state == IDLE) & mdu.Start & ~mdu.Flush & dz;
`else
   assign dz = 1'b0;
`endif

   assign issue      = (state == IDLE) & mdu.Start & is_md & ~mdu.Flush & ~dz;
   assign mdu.Busy   = (state != IDLE) | issue;
   assign mdu.HI     = hi_q;
   assign mdu.LO     = lo_q;
   assign mdu.Result = (mdu.E_func == F_MFHI) ? hi_q :
                       (mdu.E_func == F_MFLO) ? lo_q : '0;

   // Multiply: acc_lo holds the multiplier and shifts right into the product.
   // Divide: {acc_hi,acc_lo} is {remainder,dividend->quotient}, shifting left.
   assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
   assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opnd_b};
   assign prod_neg  = -{acc_hi, acc_lo};

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state  <= IDLE;
         cnt    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         opnd_b <= '0;
         op_mul <= 1'b0;
         sign_p <= 1'b0;
         sign_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (issue) begin
                  acc_hi <= '0;
                  acc_lo <= abs_a;
                  opnd_b <= abs_b;
                  op_mul <= ~mdu.E_func[1];
                  sign_p <= is_signed & (mdu.E_busA[WIDTH-1] ^ mdu.E_busB[WIDTH-1]);
                  sign_r <= is_signed & mdu.E_busA[WIDTH-1];
                  cnt    <= CNT_W'(WIDTH-1);
                  state  <= RUN;
               end else if (mdu.Start & ~mdu.Flush) begin
                  if (mdu.E_func == F_MTHI) hi_q <= mdu.E_busA;
                  if (mdu.E_func == F_MTLO) lo_q <= mdu.E_busA;
               end
            end
            RUN: begin
               if (mdu.Flush) begin
                  state <= IDLE;
               end else begin
                  if (op_mul) begin
                     {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                  end else if (!div_diff[WIDTH]) begin
                     acc_hi <= div_diff[WIDTH-1:0];
                     acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                  end else begin
                     acc_hi <= div_shift[WIDTH-1:0];
                     acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                  end
                  if (cnt == '0) state <= FIX;
                  else           cnt   <= cnt - 1'b1;
               end
            end
            FIX: begin
               state <= IDLE;
               if (!mdu.Flush) begin
                  if (op_mul) begin
                     {hi_q, lo_q} <= sign_p ? prod_neg : {acc_hi, acc_lo};
                  end else begin
                     lo_q <= sign_p ? -acc_lo : acc_lo;
                     hi_q <= sign_r ? -acc_hi : acc_hi;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
